// File: rtl/alu_ctrl_mdu_pkg.sv
// Shared encodings for the ALU control decoder and the iterative multiply/divide unit.
// Holds the select codes, alu_op classes, funct codes and the MDU state enum.
package alu_ctrl_mdu_pkg;

    localparam int SEL_CODE_W = 4;

    localparam logic [SEL_CODE_W-1:0] SEL_AND  = 4'b0000;
    localparam logic [SEL_CODE_W-1:0] SEL_OR   = 4'b0001;
    localparam logic [SEL_CODE_W-1:0] SEL_ADD  = 4'b0010;
    localparam logic [SEL_CODE_W-1:0] SEL_SUB  = 4'b0110;
    localparam logic [SEL_CODE_W-1:0] SEL_SLT  = 4'b0111;
    localparam logic [SEL_CODE_W-1:0] SEL_SLTU = 4'b1000;
    localparam logic [SEL_CODE_W-1:0] SEL_NOR  = 4'b1100;
    localparam logic [SEL_CODE_W-1:0] SEL_XOR  = 4'b1101;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_ORI   = 2'b11;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_t;

    function automatic logic [SEL_CODE_W-1:0] rtype_select(input logic [5:0] funct);
        logic [SEL_CODE_W-1:0] code;
        code = SEL_AND;
        case (funct)
            FUNCT_ADD, FUNCT_ADDU: code = SEL_ADD;
            FUNCT_SUB, FUNCT_SUBU: code = SEL_SUB;
            FUNCT_AND:             code = SEL_AND;
            FUNCT_OR:              code = SEL_OR;
            FUNCT_XOR:             code = SEL_XOR;
            FUNCT_NOR:             code = SEL_NOR;
            FUNCT_SLT:             code = SEL_SLT;
            FUNCT_SLTU:            code = SEL_SLTU;
            default:               code = SEL_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_ctrl_mdu_mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath, one bit per step.
// res_hi/res_lo present the value the partial registers take on the current step.
module mdu_iter
    import alu_ctrl_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             start,
    input  logic             step,
    input  logic             op_div,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    // acc: product upper half / running remainder; aux: multiplier / dividend->quotient
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] aux_q;
    logic [WIDTH-1:0] opnd_q;
    logic             div_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] aux_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (aux_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, aux_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        acc_next  = acc_q;
        aux_next  = aux_q;
        if (div_q) begin
            // A non-negative trial difference means the divisor fits: keep it, emit a 1
            if (!div_diff[WIDTH+1]) begin
                acc_next = div_diff[WIDTH-1:0];
                aux_next = {aux_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = div_shift[WIDTH-1:0];
                aux_next = {aux_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = mul_sum[WIDTH:1];
            aux_next = {mul_sum[0], aux_q[WIDTH-1:1]};
        end
    end

    assign res_hi = acc_next;
    assign res_lo = aux_next;

    always_ff @(posedge clk) begin
        if (start) begin
            acc_q  <= '0;
            aux_q  <= op_div ? rs_val : rt_val;
            opnd_q <= op_div ? rt_val : rs_val;
            div_q  <= op_div;
        end else if (step) begin
            acc_q <= acc_next;
            aux_q <= aux_next;
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with an attached iterative MULTU/DIVU unit, its FSM and the
// pipeline interlock that holds MDU and MFHI/MFLO instructions while the unit is busy.
module alu_ctrl_mdu
    import alu_ctrl_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [SEL_W-1:0] select,
    output logic             mfhi,
    output logic             mflo,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mdu_state_t       state_q;
    mdu_state_t       state_next;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_CODE_W-1:0] sel_code;
    logic             is_rtype;
    logic             mdu_op;
    logic             accept;
    logic             finish;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    always_comb begin
        sel_code = SEL_AND;
        case (alu_op)
            ALU_OP_ADD:   sel_code = SEL_ADD;
            ALU_OP_SUB:   sel_code = SEL_SUB;
            ALU_OP_RTYPE: sel_code = rtype_select(funct);
            ALU_OP_ORI:   sel_code = SEL_OR;
            default:      sel_code = SEL_AND;
        endcase
    end

    assign select   = SEL_W'(sel_code);
    assign is_rtype = valid && (alu_op == ALU_OP_RTYPE);
    assign mfhi     = is_rtype && (funct == FUNCT_MFHI);
    assign mflo     = is_rtype && (funct == FUNCT_MFLO);
    assign mdu_op   = is_rtype && ((funct == FUNCT_MULTU) || (funct == FUNCT_DIVU));
    assign accept   = mdu_op && (state_q == ST_IDLE);
    assign finish   = (state_q == ST_RUN) && (cnt_q == LAST_CNT);

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign stall = (mdu_op && (state_q != ST_IDLE)) || ((mfhi || mflo) && (state_q == ST_RUN));

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_next = ST_RUN;
            ST_RUN:  if (finish) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_next;
            if (accept) begin
                cnt_q <= '0;
            end else if (state_q == ST_RUN) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Results become architecturally visible only when the last iteration retires
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (finish) begin
            hi <= res_hi;
            lo <= res_lo;
        end
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu_iter (
        .clk   (clk),
        .start (accept),
        .step  (state_q == ST_RUN),
        .op_div(funct == FUNCT_DIVU),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .res_hi(res_hi),
        .res_lo(res_lo)
    );

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu (WIDTH=32): decode sweep, directed and random
// MULTU/DIVU against an arithmetic reference, interlock, mid-op reset and back-to-back ops.
module tb_alu_ctrl_mdu;

    localparam int WIDTH = 32;
    localparam int SEL_W = 4;

    logic             clk;
    logic             reset;
    logic             valid;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [SEL_W-1:0] select;
    logic             mfhi;
    logic             mflo;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_ctrl_mdu #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .alu_op(alu_op),
        .funct (funct),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .select(select),
        .mfhi  (mfhi),
        .mflo  (mflo),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned arithmetic, {hi,lo}
    function automatic logic [63:0] ref_mdu(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (is_div) begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else            r = {a % b, a / b};
        end else begin
            r = {32'd0, a} * {32'd0, b};
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_select(input int op, input int f);
        logic [3:0] s;
        s = 4'd0;
        if (op == 0) s = 4'd2;
        else if (op == 1) s = 4'd6;
        else if (op == 3) s = 4'd1;
        else begin
            if (f == 32 || f == 33) s = 4'd2;
            else if (f == 34 || f == 35) s = 4'd6;
            else if (f == 36) s = 4'd0;
            else if (f == 37) s = 4'd1;
            else if (f == 38) s = 4'd13;
            else if (f == 39) s = 4'd12;
            else if (f == 42) s = 4'd7;
            else if (f == 43) s = 4'd8;
            else s = 4'd0;
        end
        return s;
    endfunction

    // Stimulus only: issue one MDU op from a negedge and observe WIDTH+4 cycles after the accept edge.
    task automatic issue_and_wait(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output int done_cyc, output int busy_cnt, output int done_cnt,
                                  output logic [31:0] h, output logic [31:0] l, output bit early);
        logic [31:0] h0;
        logic [31:0] l0;
        valid  = 1'b1;
        alu_op = 2'b10;
        funct  = f;
        rs_val = a;
        rt_val = b;
        h0 = hi;
        l0 = lo;
        @(posedge clk);
        @(negedge clk);
        valid  = 1'b0;
        funct  = 6'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
        done_cyc = -1; busy_cnt = 0; done_cnt = 0; early = 1'b0; h = '0; l = '0;
        for (int k = 1; k <= WIDTH + 4; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k; h = hi; l = lo;
                end
            end else if (done_cyc < 0 && (hi !== h0 || lo !== l0)) begin
                early = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({busy, done, stall} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, done, stall}); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_hilo got %h_%h want 0_0", hi, lo); end
        valid = 1'b1; alu_op = 2'b10; funct = 6'b011001; rs_val = $urandom; rt_val = $urandom;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; valid = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_priority busy got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_priority_hold got %b%b want 00", busy, done); end
    endtask

    task automatic test_decode;
        logic [3:0] es;
        bit v;
        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 64; f++) begin
                v = 1'($urandom);
                valid = v; alu_op = 2'(op); funct = 6'(f);
                #1;
                es = ref_select(op, f);
                n_cmp++; if (select !== es) begin n_fail++; $display("FAIL decode_select op=%0d f=%0d got %h want %h", op, f, select, es); end
                n_cmp++; if (mfhi !== (v && op == 2 && f == 16) || mflo !== (v && op == 2 && f == 18)) begin
                    n_fail++; $display("FAIL decode_mfhilo op=%0d f=%0d v=%0d got %b%b", op, f, v, mfhi, mflo);
                end
                n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL decode_idle_stall op=%0d f=%0d got %b want 0", op, f, stall); end
                valid = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_multu_directed;
        int dc, bc, dn; logic [31:0] h, l; bit e;
        issue_and_wait(6'b011001, 32'hFFFF_FFFF, 32'h0000_0002, dc, bc, dn, h, l, e);
        n_cmp++; if (dc != 33) begin n_fail++; $display("FAIL multu_done_cycle got %0d want 33", dc); end
        n_cmp++; if (bc != 33) begin n_fail++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
        n_cmp++; if (dn != 1) begin n_fail++; $display("FAIL multu_done_pulses got %0d want 1", dn); end
        n_cmp++; if (h !== 32'h1 || l !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_result got %h_%h want 00000001_fffffffe", h, l); end
        n_cmp++; if (e) begin n_fail++; $display("FAIL multu_hilo_early got changed want held"); end
    endtask

    task automatic test_divu_directed;
        int dc, bc, dn; logic [31:0] h, l; bit e;
        issue_and_wait(6'b011011, 32'd100, 32'd7, dc, bc, dn, h, l, e);
        n_cmp++; if (dc != 33 || h !== 32'd2 || l !== 32'hE) begin n_fail++; $display("FAIL divu_100_7 got cyc=%0d %h_%h want 33 00000002_0000000e", dc, h, l); end
        issue_and_wait(6'b011011, 32'd5, 32'd0, dc, bc, dn, h, l, e);
        n_cmp++; if (dc != 33 || h !== 32'd5 || l !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by_zero got cyc=%0d %h_%h want 33 00000005_ffffffff", dc, h, l); end
    endtask

    task automatic test_random_ops;
        int dc, bc, dn; logic [31:0] h, l; bit e; bit is_div; logic [31:0] a, b; logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            is_div = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = a + 32'd1;
                default: b = $urandom;
            endcase
            exp = ref_mdu(is_div, a, b);
            issue_and_wait(is_div ? 6'b011011 : 6'b011001, a, b, dc, bc, dn, h, l, e);
            n_cmp++; if ({h, l} !== exp || dc != 33 || dn != 1 || e) begin
                n_fail++; $display("FAIL random_op div=%0d a=%h b=%h got cyc=%0d n=%0d %h_%h want 33 1 %h", is_div, a, b, dc, dn, h, l, exp);
            end
        end
    endtask

    task automatic test_mflo_stall;
        logic [31:0] a, b; logic [63:0] exp;
        a = $urandom | 32'h1; b = $urandom | 32'h100;
        exp = ref_mdu(1'b0, a, b);
        valid = 1'b1; alu_op = 2'b10; funct = 6'b011001; rs_val = a; rt_val = b;
        @(posedge clk);
        @(negedge clk);
        funct = 6'b010010;
        for (int k = 1; k <= 33; k++) begin
            if (k > 1) @(negedge clk);
            n_cmp++; if (stall !== (k <= 32)) begin n_fail++; $display("FAIL mflo_stall cycle=%0d got %b want %b", k, stall, (k <= 32)); end
        end
        n_cmp++; if (done !== 1'b1 || mflo !== 1'b1 || lo !== exp[31:0]) begin
            n_fail++; $display("FAIL mflo_in_done got done=%b mflo=%b lo=%h want 1 1 %h", done, mflo, lo, exp[31:0]);
        end
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        int dc, bc, dn, spurious; logic [31:0] h, l; bit e; logic [31:0] a, b; logic [63:0] exp;
        valid = 1'b1; alu_op = 2'b10; funct = 6'b011001; rs_val = $urandom; rt_val = $urandom;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        for (int k = 2; k <= 9; k++) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midop_reset_flags got %b%b want 00", busy, done); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL midop_reset_hilo got %h_%h want 0_0", hi, lo); end
        spurious = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        n_cmp++; if (spurious != 0) begin n_fail++; $display("FAIL midop_no_done got %0d active cycles want 0", spurious); end
        a = $urandom; b = 32'($urandom_range(1, 1000));
        exp = ref_mdu(1'b1, a, b);
        issue_and_wait(6'b011011, a, b, dc, bc, dn, h, l, e);
        n_cmp++; if ({h, l} !== exp || dc != 33) begin n_fail++; $display("FAIL midop_next_divu got cyc=%0d %h_%h want 33 %h", dc, h, l, exp); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a1, b1, a2, b2; logic [63:0] e1, e2;
        logic st [1:70]; logic bz [1:70]; logic dn [1:70]; logic [63:0] hl [1:70];
        int bad_stall, bad_done, bad_busy;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = 32'($urandom_range(1, 50000));
        e1 = ref_mdu(1'b0, a1, b1); e2 = ref_mdu(1'b1, a2, b2);
        valid = 1'b1; alu_op = 2'b10; funct = 6'b011001; rs_val = a1; rt_val = b1;
        @(posedge clk);
        @(negedge clk);
        funct = 6'b011011; rs_val = a2; rt_val = b2;
        for (int k = 1; k <= 70; k++) begin
            if (k > 1) @(negedge clk);
            st[k] = stall; bz[k] = busy; dn[k] = done; hl[k] = {hi, lo};
            if (k >= 35) begin
                valid = 1'b0; rs_val = $urandom; rt_val = $urandom;
            end
        end
        bad_stall = 0; bad_done = 0; bad_busy = 0;
        for (int k = 1; k <= 34; k++) if (st[k] !== (k <= 33)) bad_stall++;
        for (int k = 1; k <= 70; k++) begin
            if (dn[k] !== (k == 33 || k == 67)) bad_done++;
            if (bz[k] !== (k != 34 && k <= 67)) bad_busy++;
        end
        n_cmp++; if (bad_stall != 0) begin n_fail++; $display("FAIL b2b_stall got %0d wrong cycles want 0", bad_stall); end
        n_cmp++; if (bad_done != 0) begin n_fail++; $display("FAIL b2b_done got %0d wrong cycles want 0", bad_done); end
        n_cmp++; if (bad_busy != 0) begin n_fail++; $display("FAIL b2b_busy got %0d wrong cycles want 0", bad_busy); end
        n_cmp++; if (hl[33] !== e1) begin n_fail++; $display("FAIL b2b_multu got %h want %h", hl[33], e1); end
        n_cmp++; if (hl[67] !== e2 || hl[66] !== e1) begin n_fail++; $display("FAIL b2b_divu got %h (prior %h) want %h (prior %h)", hl[67], hl[66], e2, e1); end
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; alu_op = 2'b00; funct = 6'd0; rs_val = '0; rt_val = '0;
        @(negedge clk);
        test_reset();
        test_decode();
        test_multu_directed();
        test_divu_directed();
        test_random_ops();
        test_mflo_stall();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
